ysyx_23060025_burst_rd_bridge: RTL and testbench
================================================

YSYX_23060025_BURST_RD_BRIDGE -- requirements
Module: ysyx_23060025_burst_rd_bridge

Interface
REQ-001 SHALL have parameter ARID, default 0, meaning the fixed AXI ID driven on m_arid and expected on m_rid.
REQ-002 SHALL have parameter ID_W, default 4, meaning the AXI ID width.
REQ-003 SHALL use clock, named clock, as the only clock; reset, named reset, is synchronous and active-high.
REQ-004 Ports, one per line (name, direction, width, meaning):
- clock  in  1  clock
- reset  in  1  sync active-high reset
- req_psel  in  1  cache burst request; level signal, held high until burst consumed
- req_paddr  in  32  burst start address
- req_arlen  in  8  beats minus 1
- req_arsize  in  3  beat size code
- req_rvalid  out  1  data beat valid to cache; cache always accepts
- req_rlast  out  1  final beat of burst
- req_rdata  out  32  beat data
- req_err  out  1  burst error; valid with req_rlast
- m_arvalid  out  1  AXI AR valid
- m_arready  in  1  AXI AR ready
- m_araddr  out  32  AXI AR address
- m_arid  out  ID_W  AXI AR ID
- m_arlen  out  8  AXI AR length
- m_arsize  out  3  AXI AR size
- m_arburst  out  2  AXI AR burst type
- m_rvalid  in  1  AXI R valid
- m_rready  out  1  AXI R ready
- m_rdata  in  32  AXI R data
- m_rresp  in  2  AXI R response
- m_rlast  in  1  AXI R last
- m_rid  in  ID_W  AXI R ID

Function
REQ-005 SHALL implement states IDLE, ADDR, DATA, DRAIN, DONE.
REQ-006 IDLE: on req_psel=1, latch req_paddr/req_arlen/req_arsize; clear beat counter and error flag; go to ADDR next cycle.
REQ-007 ADDR: m_arvalid=1; m_araddr/m_arlen/m_arsize come from latched values; m_arburst=2'b01 (INCR); m_arid=ARID; all held stable until m_arready=1; on handshake go to DATA.
REQ-008 m_arvalid SHALL NOT depend combinationally on m_arready.
REQ-009 DATA: m_rready=1; m_rready=0 in every other state.
REQ-010 Each accepted R beat (m_rvalid&m_rready) SHALL appear on req_rvalid/req_rdata exactly one cycle later (registered); req_rvalid=0 otherwise.
REQ-011 Beat counter SHALL increment per accepted beat; req_rlast SHALL be asserted with the beat where counter==latched arlen, or with any beat carrying m_rlast=1, whichever comes first.
REQ-012 Error flag SHALL set on any accepted beat with m_rresp!=0, m_rid!=ARID, m_rlast=1 before counter==arlen, or m_rlast=0 at counter==arlen; req_err SHALL equal (flag including the current beat) in the req_rlast cycle and be 0 otherwise.
REQ-013 After the last forwarded beat: if m_rlast was seen, go to DONE; else go to DRAIN.
REQ-014 DRAIN: m_rready=1; beats discarded (not forwarded); on m_rlast go to DONE.
REQ-015 DONE: wait for req_psel=0, then IDLE; a still-high req_psel SHALL NOT start a new burst.
REQ-016 Counter SHALL be 9 bits; arlen=255 (256 beats) SHALL complete without wrap.
REQ-017 arlen=0 SHALL yield one beat with req_rvalid and req_rlast together.

Reset
REQ-018 reset SHALL force IDLE; clear counter and error flag; drive all outputs to 0 (m_arburst included) on the next edge, including mid-burst.
REQ-019 After mid-burst reset, the stale AXI R beats are not tracked; the system resets the interconnect together with this block.

Structure
REQ-020 State encodings, AXI_BURST_INCR, and AXI_RESP codes SHALL live in the shared define file alongside AXI_ADDR_SIZE_*.
REQ-021 SHALL be a single module with no sub-modules.

Verification
REQ-022 arlen=3, size=4B, addr 0x8000_0010, arready after 2 cycles, 4 beats 0x11..0x44 with rlast on beat 4: 4 req beats one cycle delayed, req_rlast on 0x44, req_err=0, return to IDLE after psel drops.
REQ-023 arlen=0, single beat 0xDEADBEEF with rlast: req_rvalid=req_rlast=1 in the same cycle, req_err=0.
REQ-024 arlen=3, beat 2 with rresp=2'b10: all 4 beats forwarded, req_err=1 only with req_rlast.
REQ-025 arlen=3, slave asserts rlast on beat 2: req_rlast on beat 2, req_err=1, DONE; the slave gives 6 beats with rlast on beat 6: req_rlast on beat 4, req_err=1, beats 5-6 drained and not forwarded.
REQ-026 reset asserted after the 2nd of 4 beats: all outputs 0 next cycle, state IDLE; a new psel then issues a fresh AR with correct address.
REQ-027 psel held high for 3 cycles after req_rlast: no second AR issued; IDLE one cycle after psel falls.

Source files
------------

// File: rtl/ysyx_23060025_burst_rd_bridge_pkg.sv
// Shared AXI encodings and bridge FSM states for the burst read bridge.
package ysyx_23060025_burst_rd_bridge_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_DATA  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam logic [2:0] AXI_ADDR_SIZE_1B   = 3'd0;
  localparam logic [2:0] AXI_ADDR_SIZE_2B   = 3'd1;
  localparam logic [2:0] AXI_ADDR_SIZE_4B   = 3'd2;
  localparam logic [2:0] AXI_ADDR_SIZE_8B   = 3'd3;
  localparam logic [2:0] AXI_ADDR_SIZE_16B  = 3'd4;
  localparam logic [2:0] AXI_ADDR_SIZE_32B  = 3'd5;
  localparam logic [2:0] AXI_ADDR_SIZE_64B  = 3'd6;
  localparam logic [2:0] AXI_ADDR_SIZE_128B = 3'd7;

endpackage

// File: rtl/ysyx_23060025_burst_rd_bridge.sv
// Converts a held cache burst request into one AXI INCR read burst and
// forwards the returned beats, registered, with last/error framing.
module ysyx_23060025_burst_rd_bridge
  import ysyx_23060025_burst_rd_bridge_pkg::*;
#(
  parameter int unsigned ARID = 0,
  parameter int          ID_W = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            req_psel,
  input  logic [31:0]     req_paddr,
  input  logic [7:0]      req_arlen,
  input  logic [2:0]      req_arsize,
  output logic            req_rvalid,
  output logic            req_rlast,
  output logic [31:0]     req_rdata,
  output logic            req_err,
  output logic            m_arvalid,
  input  logic            m_arready,
  output logic [31:0]     m_araddr,
  output logic [ID_W-1:0] m_arid,
  output logic [7:0]      m_arlen,
  output logic [2:0]      m_arsize,
  output logic [1:0]      m_arburst,
  input  logic            m_rvalid,
  output logic            m_rready,
  input  logic [31:0]     m_rdata,
  input  logic [1:0]      m_rresp,
  input  logic            m_rlast,
  input  logic [ID_W-1:0] m_rid
);

  localparam logic [ID_W-1:0] ARID_V = ID_W'(ARID);

  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // the AR side holds all fields stable while valid is high and not ready.
  state_e      state, state_n;
  logic [31:0] addr_q;
  logic [7:0]  len_q;
  logic [2:0]  size_q;
  logic [8:0]  cnt_q;
  logic        err_q;
  logic        rvalid_q, rlast_q, rerr_q;
  logic [31:0] rdata_q;

  logic beat, at_last, fwd_last, beat_bad, in_addr;

  assign in_addr  = (state == S_ADDR);
  assign beat     = (state == S_DATA) && m_rvalid;
  assign at_last  = (cnt_q == {1'b0, len_q});
  assign fwd_last = beat && (at_last || m_rlast);
  assign beat_bad = (m_rresp != AXI_RESP_OKAY) || (m_rid != ARID_V) || (m_rlast != at_last);

  // AR fields are gated by state so every output reads zero out of reset.
  assign m_arvalid = in_addr;
  assign m_araddr  = in_addr ? addr_q : 32'd0;
  assign m_arlen   = in_addr ? len_q : 8'd0;
  assign m_arsize  = in_addr ? size_q : 3'd0;
  assign m_arburst = in_addr ? AXI_BURST_INCR : 2'b00;
  assign m_arid    = in_addr ? ARID_V : '0;
  assign m_rready  = (state == S_DATA) || (state == S_DRAIN);

  assign req_rvalid = rvalid_q;
  assign req_rlast  = rlast_q;
  assign req_rdata  = rdata_q;
  assign req_err    = rerr_q;

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (req_psel) state_n = S_ADDR;
      S_ADDR:  if (m_arready) state_n = S_DATA;
      S_DATA:  if (fwd_last) state_n = m_rlast ? S_DONE : S_DRAIN;
      S_DRAIN: if (m_rvalid && m_rlast) state_n = S_DONE;
      S_DONE:  if (!req_psel) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      addr_q   <= 32'd0;
      len_q    <= 8'd0;
      size_q   <= 3'd0;
      cnt_q    <= 9'd0;
      err_q    <= 1'b0;
      rvalid_q <= 1'b0;
      rlast_q  <= 1'b0;
      rerr_q   <= 1'b0;
      rdata_q  <= 32'd0;
    end else begin
      if (state == S_IDLE && req_psel) begin
        addr_q <= req_paddr;
        len_q  <= req_arlen;
        size_q <= req_arsize;
        cnt_q  <= 9'd0;
        err_q  <= 1'b0;
      end else if (beat) begin
        cnt_q <= cnt_q + 9'd1;
        err_q <= err_q || beat_bad;
      end
      rvalid_q <= beat;
      rdata_q  <= beat ? m_rdata : 32'd0;
      rlast_q  <= fwd_last;
      // The error reported with the last beat includes that beat's own fault.
      rerr_q   <= fwd_last && (err_q || beat_bad);
    end
  end

endmodule

// File: tb/tb_ysyx_23060025_burst_rd_bridge.sv
// Directed plus randomized bursts against a burst-level reference model.
module tb_ysyx_23060025_burst_rd_bridge;
  import ysyx_23060025_burst_rd_bridge_pkg::*;

  localparam int         ID_W    = 4;
  localparam logic [3:0] TB_ARID = 4'd3;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            req_psel = 1'b0;
  logic [31:0]     req_paddr = '0;
  logic [7:0]      req_arlen = '0;
  logic [2:0]      req_arsize = '0;
  logic            req_rvalid, req_rlast, req_err;
  logic [31:0]     req_rdata;
  logic            m_arvalid;
  logic            m_arready = 1'b0;
  logic [31:0]     m_araddr;
  logic [ID_W-1:0] m_arid;
  logic [7:0]      m_arlen;
  logic [2:0]      m_arsize;
  logic [1:0]      m_arburst;
  logic            m_rvalid = 1'b0;
  logic            m_rready;
  logic [31:0]     m_rdata = '0;
  logic [1:0]      m_rresp = '0;
  logic            m_rlast = 1'b0;
  logic [ID_W-1:0] m_rid = '0;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit mon_en = 1'b0;
  // Entry: {expected output cycle, last, err, data}
  logic [65:0] exp_q[$];
  logic [65:0] e;

  ysyx_23060025_burst_rd_bridge #(.ARID(int'(TB_ARID)), .ID_W(ID_W)) dut (
    .clock(clock), .reset(reset),
    .req_psel(req_psel), .req_paddr(req_paddr), .req_arlen(req_arlen), .req_arsize(req_arsize),
    .req_rvalid(req_rvalid), .req_rlast(req_rlast), .req_rdata(req_rdata), .req_err(req_err),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arid(m_arid),
    .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
    .m_rlast(m_rlast), .m_rid(m_rid)
  );

  // Clock / reset
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req"}, {req_rvalid, req_rlast, req_err, req_rdata, m_rready}, 64'd0);
    chk({tag, "_ar"}, {m_arvalid, m_araddr, m_arid, m_arlen, m_arsize, m_arburst}, 64'd0);
    chk({tag, "_state"}, 64'(dut.state), 64'(S_IDLE));
  endtask

  // Scoreboard: every cycle either pops one expected beat or sees quiet flags.
  always @(negedge clock) begin
    if (mon_en) begin
      if (req_rvalid) begin
        chk("beat_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("beat_cycle", 64'(cyc), 64'(e[65:34]));
          chk("beat_data", 64'(req_rdata), 64'(e[31:0]));
          chk("beat_last", 64'(req_rlast), 64'(e[33]));
          chk("beat_err", 64'(req_err), 64'(e[32]));
        end
      end else begin
        chk("quiet_flags", {62'd0, req_rlast, req_err}, 64'd0);
      end
    end
  end

  // Driver: one cache request plus the slave side of the AXI burst.
  // rlast_at/bad_*_at are 1-based slave beat indices (0 = none).
  task automatic do_burst(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                          input int rlast_at, input int bad_resp_at, input int bad_id_at,
                          input int ar_delay, input int abort_after, input int hold,
                          input logic [31:0] dbase);
    int  fwd;
    bit  err;
    int  guard;
    // Reference model: forward until arlen+1 beats or the first rlast,
    // flag an error on a misplaced rlast or any bad forwarded beat.
    fwd = (rlast_at < int'(len) + 1) ? rlast_at : int'(len) + 1;
    err = (rlast_at != int'(len) + 1) ||
          (bad_resp_at >= 1 && bad_resp_at <= fwd) ||
          (bad_id_at >= 1 && bad_id_at <= fwd);

    req_psel = 1'b1; req_paddr = addr; req_arlen = len; req_arsize = size;
    tick();
    req_paddr = $urandom; req_arlen = 8'($urandom); req_arsize = 3'($urandom);
    guard = 0;
    while (!m_arvalid && guard < 8) begin tick(); guard++; end
    chk("arvalid", 64'(m_arvalid), 64'd1);
    chk("araddr", 64'(m_araddr), 64'(addr));
    chk("arlen", 64'(m_arlen), 64'(len));
    chk("arsize", 64'(m_arsize), 64'(size));
    chk("arburst", 64'(m_arburst), 64'(2'b01));
    chk("arid", 64'(m_arid), 64'(TB_ARID));
    for (int d = 0; d < ar_delay; d++) begin
      chk("ar_hold", {31'd0, m_arvalid, m_araddr}, {31'd0, 1'b1, addr});
      chk("rready_in_addr", 64'(m_rready), 64'd0);
      tick();
    end
    m_arready = 1'b1;
    tick();
    m_arready = 1'b0;
    chk("arvalid_drop", 64'(m_arvalid), 64'd0);

    for (int i = 1; i <= rlast_at; i++) begin
      if (abort_after != 0 && i > abort_after) break;
      repeat ($urandom_range(0, 2)) tick();
      m_rvalid = 1'b1;
      m_rdata  = (dbase != 0) ? dbase * 32'(i) : $urandom;
      m_rresp  = (i == bad_resp_at) ? 2'b10 : 2'b00;
      m_rid    = (i == bad_id_at) ? (TB_ARID ^ 4'd1) : TB_ARID;
      m_rlast  = (i == rlast_at);
      chk("rready", 64'(m_rready), 64'd1);
      if (i <= fwd)
        exp_q.push_back({32'(cyc + 1), (i == fwd), (i == fwd) && err, m_rdata});
      tick();
      m_rvalid = 1'b0; m_rlast = 1'b0; m_rresp = 2'b00;
    end

    if (abort_after != 0) begin
      reset = 1'b1; req_psel = 1'b0;
      tick();
      chk_all_zero("mid_reset");
      reset = 1'b0;
      return;
    end

    tick();
    chk("state_done", 64'(dut.state), 64'(S_DONE));
    chk("rready_done", 64'(m_rready), 64'd0);
    for (int h = 0; h < hold; h++) begin
      chk("no_second_ar", 64'(m_arvalid), 64'd0);
      tick();
    end
    chk("state_done_held", 64'(dut.state), 64'(S_DONE));
    req_psel = 1'b0;
    tick();
    chk("state_idle", 64'(dut.state), 64'(S_IDLE));
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int len, rl, br, bi;
    reset = 1'b1;
    repeat (2) tick();
    chk_all_zero("reset");
    reset = 1'b0;
    mon_en = 1'b1;
    tick();

    do_burst(32'h8000_0010, 8'd3, 3'd2, 4, 0, 0, 2, 0, 3, 32'h11);
    do_burst(32'h8000_0040, 8'd0, 3'd2, 1, 0, 0, 0, 0, 0, 32'hDEAD_BEEF);
    do_burst(32'h8000_0080, 8'd3, 3'd2, 4, 2, 0, 1, 0, 1, 32'd0);
    do_burst(32'h8000_00C0, 8'd3, 3'd2, 2, 0, 0, 0, 0, 0, 32'd0);
    do_burst(32'h8000_0100, 8'd3, 3'd2, 6, 0, 0, 3, 0, 0, 32'd0);
    do_burst(32'h8000_0140, 8'd5, 3'd2, 6, 0, 3, 0, 0, 0, 32'd0);
    do_burst(32'h8000_0180, 8'd3, 3'd2, 4, 0, 0, 1, 2, 0, 32'd0);
    do_burst(32'h8000_0200, 8'd3, 3'd2, 4, 0, 0, 0, 0, 0, 32'd0);
    do_burst(32'h8000_1000, 8'd255, 3'd2, 256, 0, 0, 1, 0, 0, 32'd0);

    for (int n = 0; n < 10; n++) begin
      len = $urandom_range(0, 15);
      rl  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, len + 3) : len + 1;
      br  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, rl) : 0;
      bi  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, rl) : 0;
      do_burst($urandom, 8'(len), 3'($urandom_range(0, 2)), rl, br, bi,
               $urandom_range(0, 3), 0, $urandom_range(0, 2), 32'd0);
    end

    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    total++;
    bad++;
    $display("FAIL timeout observed=running expected=finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
